auto_load_capture: RTL and testbench

//  Downstream of the auto-load sequencer. Captures the 34 flash words read back from the last BPI

---
 rtl/auto_load_capture_if.sv | 26 ++
 rtl/auto_load_capture.sv | 120 ++++++++++++
 tb/tb_auto_load_capture.sv | 154 +++++++++++++++
 3 files changed

// File: rtl/auto_load_capture_if.sv
// Sequencer/flash side of the auto-load constant capture block.
// The master drives load strobes and read addresses; the slave returns constants and status flags.
interface auto_load_capture_if;
  logic        AUTO_LOAD_ENA;
  logic [5:0]  AL_CNT;
  logic [15:0] RD_DATA;
  logic        RD_DATA_VLD;
  logic        CLR_AL_DONE;
  logic [5:0]  CONST_RADDR;
  logic [15:0] CONST_RDATA;
  logic        AL_DONE;
  logic        CONST_VALID;
  logic        CSUM_ERR;
  logic        BLANK;
  logic        SEQ_ERR;

  modport master (
    output AUTO_LOAD_ENA, AL_CNT, RD_DATA, RD_DATA_VLD, CLR_AL_DONE, CONST_RADDR,
    input  CONST_RDATA, AL_DONE, CONST_VALID, CSUM_ERR, BLANK, SEQ_ERR
  );

  modport slave (
    input  AUTO_LOAD_ENA, AL_CNT, RD_DATA, RD_DATA_VLD, CLR_AL_DONE, CONST_RADDR,
    output CONST_RDATA, AL_DONE, CONST_VALID, CSUM_ERR, BLANK, SEQ_ERR
  );
endinterface

// File: rtl/auto_load_capture.sv
// Captures the flash parameter block into a constant RAM, verifies its checksum and flags the result.
// AL_DONE rises 2 cycles after the last word strobe; the constant read port has 1-cycle latency.
module auto_load_capture #(
  parameter logic [5:0] MAX_ADDR = 6'd33,
  parameter int         TMR      = 0
) (
  input  logic               CLK,
  input  logic               RST,
  auto_load_capture_if.slave bus
);

  typedef enum logic [1:0] {IDLE, CAPTURE, CHECK, DONE} state_t;

  typedef struct packed {
    state_t      st;
    logic        ena_q;
    logic [5:0]  exp_cnt;
    logic [15:0] sum;
    logic [15:0] csum_rd;
    logic        blank_acc;
    logic        al_done;
    logic        const_valid;
    logic        csum_err;
    logic        blank;
    logic        seq_err;
  } ctl_t;

  localparam int COPIES = (TMR != 0) ? 3 : 1;

  ctl_t        r [COPIES];
  ctl_t        cur;
  ctl_t        nxt;
  logic        wr_en;
  logic [15:0] ram [0:MAX_ADDR];

  // Bitwise majority across the three copies; the RAM itself is not protected.
  if (TMR != 0) begin : g_vote
    assign cur = ctl_t'((r[0] & r[1]) | (r[0] & r[2]) | (r[1] & r[2]));
  end else begin : g_single
    assign cur = r[0];
  end

  always_comb begin
    nxt       = cur;
    nxt.ena_q = bus.AUTO_LOAD_ENA;
    wr_en     = 1'b0;
    case (cur.st)
      IDLE: begin
        if (bus.AUTO_LOAD_ENA && !cur.ena_q) begin
          nxt.st          = CAPTURE;
          nxt.exp_cnt     = '0;
          nxt.sum         = '0;
          nxt.blank_acc   = 1'b1;
          nxt.const_valid = 1'b0;
          nxt.csum_err    = 1'b0;
          nxt.blank       = 1'b0;
          nxt.seq_err     = 1'b0;
        end
      end
      CAPTURE: begin
        if (bus.RD_DATA_VLD) begin
          if (bus.AL_CNT > MAX_ADDR) begin
            nxt.seq_err = 1'b1;
          end else begin
            wr_en         = 1'b1;
            nxt.exp_cnt   = bus.AL_CNT + 6'd1;
            nxt.blank_acc = cur.blank_acc & (bus.RD_DATA == 16'hFFFF);
            if (bus.AL_CNT != cur.exp_cnt) nxt.seq_err = 1'b1;
            if (bus.AL_CNT < MAX_ADDR) begin
              nxt.sum = cur.sum + bus.RD_DATA;
            end else begin
              nxt.csum_rd = bus.RD_DATA;
              nxt.st      = CHECK;
            end
          end
        end
        // A word strobed alongside the ENA fall is still taken; only the final word escapes the abort.
        if (!bus.AUTO_LOAD_ENA && nxt.st != CHECK) nxt.st = IDLE;
      end
      CHECK: begin
        nxt.csum_err    = (cur.sum != cur.csum_rd);
        nxt.blank       = cur.blank_acc;
        nxt.const_valid = (cur.sum == cur.csum_rd) & !cur.blank_acc & !cur.seq_err;
        nxt.al_done     = 1'b1;
        nxt.st          = DONE;
      end
      DONE: begin
        if (bus.CLR_AL_DONE) begin
          nxt.al_done = 1'b0;
          nxt.st      = IDLE;
        end
      end
      default: nxt.st = IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      for (int i = 0; i < COPIES; i++) r[i] <= '0;
    end else begin
      for (int i = 0; i < COPIES; i++) r[i] <= nxt;
    end
  end

  always_ff @(posedge CLK) begin
    if (wr_en) ram[bus.AL_CNT] <= bus.RD_DATA;
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) bus.CONST_RDATA <= 16'h0000;
    else     bus.CONST_RDATA <= (bus.CONST_RADDR > MAX_ADDR) ? 16'h0000 : ram[bus.CONST_RADDR];
  end

  assign bus.AL_DONE     = cur.al_done;
  assign bus.CONST_VALID = cur.const_valid;
  assign bus.CSUM_ERR    = cur.csum_err;
  assign bus.BLANK       = cur.blank;
  assign bus.SEQ_ERR     = cur.seq_err;

endmodule

// File: tb/tb_auto_load_capture.sv
// Directed bench for auto_load_capture: good, bad-checksum, blank, sequence-error, abort and reset loads.
module tb_auto_load_capture;
  logic CLK = 1'b0;
  logic RST;
  always #5 CLK = ~CLK;

  auto_load_capture_if bus();
  auto_load_capture #(.MAX_ADDR(6'd33), .TMR(0)) dut (.CLK(CLK), .RST(RST), .bus(bus));

  int          vec_cnt = 0;
  int          err_cnt = 0;
  logic [15:0] words [0:33];

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic send_word(input logic [5:0] cnt, input logic [15:0] dat);
    bus.AL_CNT      = cnt;
    bus.RD_DATA     = dat;
    bus.RD_DATA_VLD = 1'b1;
    tick();
    bus.RD_DATA_VLD = 1'b0;
  endtask

  // Clears any pending AL_DONE, makes a fresh ENA rising edge, then strobes words 0..last except skip.
  task automatic run_load(input int skip, input int last);
    bus.CLR_AL_DONE   = 1'b1;
    bus.AUTO_LOAD_ENA = 1'b0;
    tick();
    bus.CLR_AL_DONE   = 1'b0;
    bus.AUTO_LOAD_ENA = 1'b1;
    tick();
    for (int i = 0; i <= last; i++) begin
      if (i != skip) send_word(i[5:0], words[i]);
    end
  endtask

  task automatic fill_counting(input logic [15:0] csum);
    for (int i = 0; i < 33; i++) words[i] = 16'(i + 1);
    words[33] = csum;
  endtask

  task automatic test_reset();
    RST = 1'b1;
    bus.AUTO_LOAD_ENA = 1'b0; bus.AL_CNT = '0; bus.RD_DATA = '0;
    bus.RD_DATA_VLD = 1'b0; bus.CLR_AL_DONE = 1'b0; bus.CONST_RADDR = '0;
    tick(); tick();
    vec_cnt++; if (bus.AL_DONE !== 1'b0) begin err_cnt++; $display("FAIL reset_al_done: got %b expected 0", bus.AL_DONE); end
    vec_cnt++; if (bus.CONST_VALID !== 1'b0) begin err_cnt++; $display("FAIL reset_const_valid: got %b expected 0", bus.CONST_VALID); end
    vec_cnt++; if ({bus.CSUM_ERR, bus.BLANK, bus.SEQ_ERR} !== 3'b000) begin err_cnt++; $display("FAIL reset_flags: got %b expected 000", {bus.CSUM_ERR, bus.BLANK, bus.SEQ_ERR}); end
    vec_cnt++; if (bus.CONST_RDATA !== 16'h0000) begin err_cnt++; $display("FAIL reset_rdata: got %h expected 0000", bus.CONST_RDATA); end
    RST = 1'b0;
    tick();
  endtask

  task automatic test_good();
    fill_counting(16'h0231);
    run_load(-1, 33);
    vec_cnt++; if (bus.AL_DONE !== 1'b0) begin err_cnt++; $display("FAIL good_done_early: got %b expected 0", bus.AL_DONE); end
    tick();
    vec_cnt++; if (bus.AL_DONE !== 1'b1) begin err_cnt++; $display("FAIL good_al_done: got %b expected 1", bus.AL_DONE); end
    vec_cnt++; if (bus.CONST_VALID !== 1'b1) begin err_cnt++; $display("FAIL good_const_valid: got %b expected 1", bus.CONST_VALID); end
    vec_cnt++; if ({bus.CSUM_ERR, bus.BLANK, bus.SEQ_ERR} !== 3'b000) begin err_cnt++; $display("FAIL good_flags: got %b expected 000", {bus.CSUM_ERR, bus.BLANK, bus.SEQ_ERR}); end
    bus.CONST_RADDR = 6'd5; tick();
    vec_cnt++; if (bus.CONST_RDATA !== 16'h0006) begin err_cnt++; $display("FAIL good_rd5: got %h expected 0006", bus.CONST_RDATA); end
    bus.CONST_RADDR = 6'd33; tick();
    vec_cnt++; if (bus.CONST_RDATA !== 16'h0231) begin err_cnt++; $display("FAIL good_rd33: got %h expected 0231", bus.CONST_RDATA); end
    bus.CONST_RADDR = 6'd34; tick();
    vec_cnt++; if (bus.CONST_RDATA !== 16'h0000) begin err_cnt++; $display("FAIL good_rd34: got %h expected 0000", bus.CONST_RDATA); end
    bus.CONST_RADDR = 6'd5;
  endtask

  task automatic test_done_hold();
    send_word(6'd5, 16'hBEEF);
    tick();
    vec_cnt++; if (bus.CONST_RDATA !== 16'h0006) begin err_cnt++; $display("FAIL done_ignore_vld: got %h expected 0006", bus.CONST_RDATA); end
    vec_cnt++; if (bus.AL_DONE !== 1'b1) begin err_cnt++; $display("FAIL done_hold: got %b expected 1", bus.AL_DONE); end
    bus.CLR_AL_DONE = 1'b1; tick(); bus.CLR_AL_DONE = 1'b0;
    vec_cnt++; if (bus.AL_DONE !== 1'b0) begin err_cnt++; $display("FAIL clr_al_done: got %b expected 0", bus.AL_DONE); end
    vec_cnt++; if (bus.CONST_VALID !== 1'b1) begin err_cnt++; $display("FAIL clr_valid_held: got %b expected 1", bus.CONST_VALID); end
  endtask

  task automatic test_bad_csum();
    fill_counting(16'h0232);
    run_load(-1, 33);
    tick();
    vec_cnt++; if (bus.AL_DONE !== 1'b1) begin err_cnt++; $display("FAIL csum_al_done: got %b expected 1", bus.AL_DONE); end
    vec_cnt++; if (bus.CSUM_ERR !== 1'b1) begin err_cnt++; $display("FAIL csum_err: got %b expected 1", bus.CSUM_ERR); end
    vec_cnt++; if (bus.CONST_VALID !== 1'b0) begin err_cnt++; $display("FAIL csum_valid: got %b expected 0", bus.CONST_VALID); end
  endtask

  task automatic test_blank();
    for (int i = 0; i < 34; i++) words[i] = 16'hFFFF;
    run_load(-1, 33);
    tick();
    vec_cnt++; if (bus.BLANK !== 1'b1) begin err_cnt++; $display("FAIL blank_flag: got %b expected 1", bus.BLANK); end
    vec_cnt++; if (bus.CSUM_ERR !== 1'b1) begin err_cnt++; $display("FAIL blank_csum: got %b expected 1", bus.CSUM_ERR); end
    vec_cnt++; if (bus.CONST_VALID !== 1'b0) begin err_cnt++; $display("FAIL blank_valid: got %b expected 0", bus.CONST_VALID); end
  endtask

  task automatic test_seq_err();
    fill_counting(16'h0231);
    run_load(7, 33);
    tick();
    vec_cnt++; if (bus.SEQ_ERR !== 1'b1) begin err_cnt++; $display("FAIL seq_err: got %b expected 1", bus.SEQ_ERR); end
    vec_cnt++; if (bus.CONST_VALID !== 1'b0) begin err_cnt++; $display("FAIL seq_valid: got %b expected 0", bus.CONST_VALID); end
    vec_cnt++; if (bus.AL_DONE !== 1'b1) begin err_cnt++; $display("FAIL seq_al_done: got %b expected 1", bus.AL_DONE); end
    vec_cnt++; if (bus.BLANK !== 1'b0) begin err_cnt++; $display("FAIL seq_blank: got %b expected 0", bus.BLANK); end
  endtask

  task automatic test_abort();
    fill_counting(16'h0231);
    run_load(-1, 10);
    bus.AUTO_LOAD_ENA = 1'b0;
    tick();
    // Remaining words arrive after the abort and must be ignored in IDLE.
    for (int i = 11; i < 34; i++) send_word(i[5:0], words[i]);
    tick(); tick();
    vec_cnt++; if (bus.AL_DONE !== 1'b0) begin err_cnt++; $display("FAIL abort_al_done: got %b expected 0", bus.AL_DONE); end
    vec_cnt++; if (bus.CONST_VALID !== 1'b0) begin err_cnt++; $display("FAIL abort_valid: got %b expected 0", bus.CONST_VALID); end
  endtask

  task automatic test_rst_mid();
    fill_counting(16'h0231);
    run_load(-1, 5);
    RST = 1'b1;
    #2;
    vec_cnt++; if (bus.CONST_VALID !== 1'b0) begin err_cnt++; $display("FAIL rst_valid: got %b expected 0", bus.CONST_VALID); end
    vec_cnt++; if ({bus.AL_DONE, bus.CSUM_ERR, bus.BLANK, bus.SEQ_ERR} !== 4'b0000) begin err_cnt++; $display("FAIL rst_flags: got %b expected 0000", {bus.AL_DONE, bus.CSUM_ERR, bus.BLANK, bus.SEQ_ERR}); end
    vec_cnt++; if (bus.CONST_RDATA !== 16'h0000) begin err_cnt++; $display("FAIL rst_rdata: got %h expected 0000", bus.CONST_RDATA); end
    bus.AUTO_LOAD_ENA = 1'b0;
    tick();
    RST = 1'b0;
    tick();
  endtask

  initial begin
    test_reset();
    test_good();
    test_done_hold();
    test_bad_csum();
    test_blank();
    test_seq_err();
    test_abort();
    test_good();
    test_rst_mid();
    test_good();
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
